// File: rtl/c2h_pkg.sv
// Shared constants and buffer-state type for the C2H frame packer.
package c2h_pkg;

  localparam int IN_W    = 64;
  localparam int FRAME_W = 4072;
  localparam int WORDS   = (FRAME_W + IN_W - 1) / IN_W;

  typedef enum logic [1:0] {
    BUF_FREE    = 2'd0,
    BUF_FILLING = 2'd1,
    BUF_FULL    = 2'd2
  } buf_st_t;

endpackage

// File: rtl/c2h_frame_packer_if.sv
// Input word stream feeding the frame packer.
// A word transfers on a clock edge where s_tvalid and s_tready are both high; the
// producer holds s_tdata/s_tlast stable while s_tvalid is high and s_tready is low.
interface c2h_frame_packer_if #(
  parameter int W = c2h_pkg::IN_W
);
  logic [W-1:0] s_tdata;
  logic         s_tvalid;
  logic         s_tlast;
  logic         s_tready;

  modport master (output s_tdata, output s_tvalid, output s_tlast, input s_tready);
  modport slave  (input s_tdata, input s_tvalid, input s_tlast, output s_tready);
endinterface

// File: rtl/c2h_frame_buf.sv
// One frame buffer: word-addressed write, zero-clear and FREE/FILLING/FULL state.
// frame_nxt is the buffer content as it will be after this clock edge.
module c2h_frame_buf #(
  parameter int IN_W    = c2h_pkg::IN_W,
  parameter int FRAME_W = c2h_pkg::FRAME_W,
  parameter int WORDS   = c2h_pkg::WORDS,
  localparam int WIDX_W = $clog2(WORDS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                wr_en,
  input  logic                wr_last,
  input  logic [WIDX_W-1:0]   wr_idx,
  input  logic [IN_W-1:0]     wr_data,
  output c2h_pkg::buf_st_t    st,
  output logic [FRAME_W-1:0]  frame_nxt
);
  import c2h_pkg::*;

  // The last word is only partly inside the frame; only its low TAIL_W bits are kept.
  localparam int TAIL_W = FRAME_W - (WORDS - 1) * IN_W;

  logic [IN_W-1:0]   word_q [WORDS-1];
  logic [IN_W-1:0]   word_d [WORDS-1];
  logic [TAIL_W-1:0] tail_q, tail_d;
  buf_st_t           st_q, st_d;

  always_comb begin
    word_d = word_q;
    tail_d = tail_q;
    st_d   = st_q;
    if (clr) begin
      for (int w = 0; w < WORDS - 1; w++) word_d[w] = '0;
      tail_d = '0;
      st_d   = BUF_FREE;
    end else if (wr_en) begin
      if (wr_idx == WIDX_W'(WORDS - 1)) tail_d = wr_data[TAIL_W-1:0];
      else                              word_d[wr_idx] = wr_data;
      st_d = wr_last ? BUF_FULL : BUF_FILLING;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int w = 0; w < WORDS - 1; w++) word_q[w] <= '0;
      tail_q <= '0;
      st_q   <= BUF_FREE;
    end else begin
      word_q <= word_d;
      tail_q <= tail_d;
      st_q   <= st_d;
    end
  end

  for (genvar w = 0; w < WORDS - 1; w++) begin : g_word
    assign frame_nxt[w*IN_W +: IN_W] = word_d[w];
  end
  assign frame_nxt[FRAME_W-1 -: TAIL_W] = tail_d;

  assign st = st_q;

endmodule

// File: rtl/c2h_frame_packer.sv
// Ping-pong frame assembler: packs input words into two frame buffers and presents
// each completed frame as a held data/data_valid pair released by data_next edges.
module c2h_frame_packer #(
  parameter int IN_W    = c2h_pkg::IN_W,
  parameter int FRAME_W = c2h_pkg::FRAME_W,
  parameter int WORDS   = c2h_pkg::WORDS,
  localparam int WIDX_W = $clog2(WORDS)
) (
  input  logic                m_axis_c2h_aclk,
  input  logic                m_axis_c2h_aresetn,
  input  logic                flush,
  c2h_frame_packer_if.slave   s_axis,
  output logic [FRAME_W-1:0]  data,
  output logic                data_valid,
  input  logic                data_next,
  output logic [15:0]         frame_count,
  output logic [1:0]          buf_full
);
  import c2h_pkg::*;

  logic               wsel_q, wsel_d;
  logic               rsel_q, rsel_d;
  logic               gap_q, gap_d;
  logic               nx_q, nx_d;
  logic [WIDX_W-1:0]  widx_q, widx_d;
  logic [15:0]        frame_count_q, frame_count_d;
  logic [FRAME_W-1:0] data_q, data_d;

  buf_st_t            st  [2];
  logic [FRAME_W-1:0] nxt [2];
  logic               tready, accept, complete, rel;
  logic [1:0]         wr_en, clr;

  assign tready          = (st[wsel_q] != BUF_FULL);
  assign s_axis.s_tready = tready;
  assign accept          = s_axis.s_tvalid & tready;
  assign complete        = accept & (s_axis.s_tlast | (widx_q == WIDX_W'(WORDS - 1)));
  assign data_valid      = (st[rsel_q] == BUF_FULL) & ~gap_q;
  // Only a rising edge of the writer's done level releases, and only while presenting.
  assign rel             = data_next & ~nx_q & data_valid;
  assign wr_en           = {accept & wsel_q, accept & ~wsel_q};
  assign clr             = {2{flush}} | {rel & rsel_q, rel & ~rsel_q};

  for (genvar b = 0; b < 2; b++) begin : g_buf
    c2h_frame_buf #(
      .IN_W    (IN_W),
      .FRAME_W (FRAME_W),
      .WORDS   (WORDS)
    ) u_buf (
      .clk       (m_axis_c2h_aclk),
      .rst_n     (m_axis_c2h_aresetn),
      .clr       (clr[b]),
      .wr_en     (wr_en[b]),
      .wr_last   (complete),
      .wr_idx    (widx_q),
      .wr_data   (s_axis.s_tdata),
      .st        (st[b]),
      .frame_nxt (nxt[b])
    );
  end

  always_comb begin
    wsel_d        = wsel_q ^ complete;
    rsel_d        = rsel_q ^ rel;
    widx_d        = complete ? '0 : widx_q + WIDX_W'(accept);
    gap_d         = rel;
    nx_d          = data_next;
    frame_count_d = frame_count_q + 16'(rel);
    if (flush) begin
      wsel_d        = 1'b0;
      rsel_d        = 1'b0;
      widx_d        = '0;
      gap_d         = 1'b0;
      nx_d          = 1'b0;
      frame_count_d = '0;
    end
    // Track the next-cycle contents of the next-cycle read buffer so data lines up with data_valid.
    data_d = rsel_d ? nxt[1] : nxt[0];
  end

  always_ff @(posedge m_axis_c2h_aclk or negedge m_axis_c2h_aresetn) begin
    if (!m_axis_c2h_aresetn) begin
      wsel_q        <= 1'b0;
      rsel_q        <= 1'b0;
      gap_q         <= 1'b0;
      nx_q          <= 1'b0;
      widx_q        <= '0;
      frame_count_q <= '0;
      data_q        <= '0;
    end else begin
      wsel_q        <= wsel_d;
      rsel_q        <= rsel_d;
      gap_q         <= gap_d;
      nx_q          <= nx_d;
      widx_q        <= widx_d;
      frame_count_q <= frame_count_d;
      data_q        <= data_d;
    end
  end

  assign data        = data_q;
  assign frame_count = frame_count_q;
  assign buf_full    = {st[1] == BUF_FULL, st[0] == BUF_FULL};

endmodule

// File: tb/tb_c2h_frame_packer.sv
// Directed bench for c2h_frame_packer with hand-computed expected frame slices.
module tb_c2h_frame_packer;
  import c2h_pkg::*;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               flush = 1'b0;
  logic               data_next = 1'b0;
  logic [FRAME_W-1:0] data;
  logic [FRAME_W-1:0] snap;
  logic               data_valid;
  logic [15:0]        frame_count;
  logic [1:0]         buf_full;
  int                 n_checks = 0;
  int                 n_fail = 0;

  c2h_frame_packer_if #(.W(IN_W)) s_if ();

  // clock/reset block
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  c2h_frame_packer dut (
    .m_axis_c2h_aclk    (clk),
    .m_axis_c2h_aresetn (rst_n),
    .flush              (flush),
    .s_axis             (s_if),
    .data               (data),
    .data_valid         (data_valid),
    .data_next          (data_next),
    .frame_count        (frame_count),
    .buf_full           (buf_full)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // driver tasks
  task automatic push(input logic [63:0] d, input logic l);
    int t = 0;
    s_if.s_tdata  = d;
    s_if.s_tvalid = 1'b1;
    s_if.s_tlast  = l;
    while (!s_if.s_tready && t < 200) begin
      tick();
      t++;
    end
    if (!s_if.s_tready) begin
      check("push_timeout", 64'(s_if.s_tready), 64'd1);
      s_if.s_tvalid = 1'b0;
      s_if.s_tlast  = 1'b0;
    end else begin
      tick();
      s_if.s_tvalid = 1'b0;
      s_if.s_tlast  = 1'b0;
    end
  endtask

  task automatic push_frame(input logic [63:0] base);
    for (int i = 0; i < 64; i++) push(base + 64'(i), 1'b0);
  endtask

  task automatic pulse_next();
    data_next = 1'b1;
    tick();
    data_next = 1'b0;
  endtask

  initial begin
    s_if.s_tdata  = '0;
    s_if.s_tvalid = 1'b0;
    s_if.s_tlast  = 1'b0;
    tick(3);
    check("rst_tready", 64'(s_if.s_tready), 64'd1);
    check("rst_dv", 64'(data_valid), 64'd0);
    check("rst_data", data[63:0], 64'd0);
    check("rst_fc", 64'(frame_count), 64'd0);
    check("rst_full", 64'(buf_full), 64'd0);
    rst_n = 1'b1;
    tick();

    // full frame of 0..63 into buffer A
    for (int i = 0; i < 63; i++) push(64'(i), 1'b0);
    check("f1_dv_before_last", 64'(data_valid), 64'd0);
    push(64'd63, 1'b0);
    check("f1_dv", 64'(data_valid), 64'd1);
    check("f1_w0", data[63:0], 64'd0);
    check("f1_w1", data[127:64], 64'd1);
    check("f1_w62", data[4031:3968], 64'd62);
    check("f1_tail", 64'(data[4071:4032]), 64'h3F);
    check("f1_full", 64'(buf_full), 64'b01);
    check("f1_tready", 64'(s_if.s_tready), 64'd1);
    snap = data;
    repeat (5) begin
      tick();
      check("f1_hold_stable", 64'(data === snap), 64'd1);
    end
    pulse_next();
    check("f1_rel_dv", 64'(data_valid), 64'd0);
    check("f1_rel_fc", 64'(frame_count), 64'd1);
    check("f1_rel_full", 64'(buf_full), 64'd0);
    tick();

    // short frame into B
    push(64'h11, 1'b0);
    push(64'h22, 1'b0);
    push(64'h33, 1'b1);
    check("sh_dv", 64'(data_valid), 64'd1);
    check("sh_full", 64'(buf_full), 64'b10);
    check("sh_w0", data[63:0], 64'h11);
    check("sh_w1", data[127:64], 64'h22);
    check("sh_w2", data[191:128], 64'h33);
    check("sh_w3", data[255:192], 64'd0);
    check("sh_tail", 64'(data[4071:4032]), 64'd0);
    pulse_next();
    check("sh_fc", 64'(frame_count), 64'd2);

    // one-word frame into reused buffer A must be zero-padded
    push(64'h44, 1'b1);
    check("pad_dv", 64'(data_valid), 64'd1);
    check("pad_w0", data[63:0], 64'h44);
    check("pad_w1", data[127:64], 64'd0);
    check("pad_w62", data[4031:3968], 64'd0);
    check("pad_tail", 64'(data[4071:4032]), 64'd0);
    check("pad_full", 64'(buf_full), 64'b01);
    pulse_next();
    check("pad_fc", 64'(frame_count), 64'd3);

    // back-to-back frames with no release
    push_frame(64'h100);
    check("bb_x_dv", 64'(data_valid), 64'd1);
    check("bb_x_w0", data[63:0], 64'h100);
    push_frame(64'h200);
    check("bb_both_full", 64'(buf_full), 64'b11);
    check("bb_tready_low", 64'(s_if.s_tready), 64'd0);
    check("bb_x_still", data[63:0], 64'h100);
    tick(2);
    check("bb_tready_held", 64'(s_if.s_tready), 64'd0);
    pulse_next();
    check("bb_gap_dv", 64'(data_valid), 64'd0);
    check("bb_tready_back", 64'(s_if.s_tready), 64'd1);
    check("bb_fc", 64'(frame_count), 64'd4);
    check("bb_rel_full", 64'(buf_full), 64'b01);
    tick();
    check("bb_y_dv", 64'(data_valid), 64'd1);
    check("bb_y_w0", data[63:0], 64'h200);
    check("bb_y_w1", data[127:64], 64'h201);
    check("bb_y_tail", 64'(data[4071:4032]), 64'h23F);
    push_frame(64'h300);
    check("bb_z_full", 64'(buf_full), 64'b11);

    // data_next held high: one release per rising edge
    data_next = 1'b1;
    tick();
    check("hold_rel_fc", 64'(frame_count), 64'd5);
    check("hold_rel_dv", 64'(data_valid), 64'd0);
    tick(3);
    check("hold_z_dv", 64'(data_valid), 64'd1);
    check("hold_z_fc", 64'(frame_count), 64'd5);
    check("hold_z_w0", data[63:0], 64'h300);
    data_next = 1'b0;
    tick();
    data_next = 1'b1;
    tick();
    check("hold_rel2_fc", 64'(frame_count), 64'd6);
    check("hold_rel2_dv", 64'(data_valid), 64'd0);
    check("hold_rel2_full", 64'(buf_full), 64'd0);
    data_next = 1'b0;
    tick();
    data_next = 1'b1;
    tick();
    check("idle_edge_ignored", 64'(frame_count), 64'd6);
    data_next = 1'b0;
    tick();

    // flush mid-fill with one buffer full
    push_frame(64'h400);
    check("fl_pre_dv", 64'(data_valid), 64'd1);
    for (int i = 0; i < 30; i++) push(64'h500 + 64'(i), 1'b0);
    check("fl_pre_full", 64'(buf_full), 64'b01);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fl_dv", 64'(data_valid), 64'd0);
    check("fl_tready", 64'(s_if.s_tready), 64'd1);
    check("fl_fc", 64'(frame_count), 64'd0);
    check("fl_full", 64'(buf_full), 64'd0);
    check("fl_data", data[63:0], 64'd0);
    push_frame(64'h600);
    check("fl_next_dv", 64'(data_valid), 64'd1);
    check("fl_next_full", 64'(buf_full), 64'b01);
    check("fl_next_w0", data[63:0], 64'h600);
    check("fl_next_w62", data[4031:3968], 64'h63E);
    check("fl_next_tail", 64'(data[4071:4032]), 64'h63F);

    // asynchronous reset while presenting
    pulse_next();
    check("ar_fc_pre", 64'(frame_count), 64'd1);
    push(64'h77, 1'b1);
    check("ar_dv_pre", 64'(data_valid), 64'd1);
    check("ar_w0_pre", data[63:0], 64'h77);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_dv", 64'(data_valid), 64'd0);
    check("ar_fc", 64'(frame_count), 64'd0);
    check("ar_full", 64'(buf_full), 64'd0);
    check("ar_data", data[63:0], 64'd0);
    check("ar_tready", 64'(s_if.s_tready), 64'd1);
    tick();
    rst_n = 1'b1;
    tick();

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
